// File: rtl/mux_arb_rr.sv
// mux_arb_rr: two-requester round-robin arbiter driving a shared 2:1 word mux.
// The chosen word goes into a single-entry output stage with a valid/ready handshake.
// Optional grant counters are enabled by defining MUX_ARB_GRANT_CNT_EN.
module mux_arb_rr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word_a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] word_b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last_grant
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b,
  input  logic             cnt_clr
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   accept_ok;
  logic   gnt_any;
  logic   gnt_b;
  logic   acc_a;
  logic   acc_b;

  // Round-robin grant: a lone requester wins outright. Under contention the
  // winner is whoever did not win last. The output stage can take a word
  // when it is empty or when it drains on this same edge.
  always_comb begin
    gnt_any   = a_valid || b_valid;
    gnt_b     = b_valid && (!a_valid || !last_grant);
    accept_ok = !out_valid || out_ready;
    a_ready   = accept_ok && a_valid && !gnt_b;
    b_ready   = accept_ok && gnt_b;
    sel       = gnt_any ? gnt_b : last_grant;
    acc_a     = a_valid && a_ready;
    acc_b     = b_valid && b_ready;
  end

  // Output-stage FSM with registered data, valid and last grant.
  // An accept has priority over a drain. A drain with no accept empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      data_out   <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc_a || acc_b) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            data_out   <= acc_b ? word_b : word_a;
            last_grant <= acc_b;
          end
        end
        FULL: begin
          if (acc_a || acc_b) begin
            data_out   <= acc_b ? word_b : word_a;
            last_grant <= acc_b;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_ARB_GRANT_CNT_EN
  // Saturating per-requester accept counters. Clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (acc_a && cnt_a != 16'hFFFF) cnt_a <= cnt_a + 16'd1;
      if (acc_b && cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: table-driven vectors with a word scoreboard, plus
// hand-written sequences for async reset and, when enabled, the grant counters.
module tb_mux_arb_rr;

  localparam logic [31:0] WA = 32'hAAAAAAAA;
  localparam logic [31:0] WB = 32'h3A3A3A3A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_a = '0, word_b = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic        a_ready, b_ready, sel, out_valid, last_grant;
  logic [31:0] data_out;
`ifdef MUX_ARB_GRANT_CNT_EN
  logic [15:0] cnt_a, cnt_b;
  logic        cnt_clr = 1'b0;
`endif

  mux_arb_rr #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .word_a(word_a), .a_valid(a_valid), .a_ready(a_ready),
    .word_b(word_b), .b_valid(b_valid), .b_ready(b_ready),
    .sel(sel), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .last_grant(last_grant)
`ifdef MUX_ARB_GRANT_CNT_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_clr(cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        av; logic bv; logic ordy;
    logic        e_ar; logic e_br; logic e_sel;
    logic        e_ov; logic [31:0] e_dout; logic e_lg;
  } vec_t;

  vec_t        vt[15];
  logic [31:0] sb[$];
  logic        exp_ov_pre;
  logic [31:0] exp_w;

  // Drive one cycle's inputs, check the combinational outputs, then step the
  // clock and check the registered outputs.
  task automatic step_chk(input int i);
    vec_t v;
    v = vt[i];
    a_valid = v.av; b_valid = v.bv; out_ready = v.ordy;
    word_a = WA; word_b = WB;
    #1;
    chk($sformatf("v%0d a_ready", i), {31'd0, a_ready}, {31'd0, v.e_ar});
    chk($sformatf("v%0d b_ready", i), {31'd0, b_ready}, {31'd0, v.e_br});
    chk($sformatf("v%0d sel", i), {31'd0, sel}, {31'd0, v.e_sel});
    // The downstream consumes a word this cycle: compare it with the oldest accepted word.
    if (exp_ov_pre && v.ordy) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL v%0d scoreboard: got %h expected nothing pending", i, data_out);
      end else begin
        exp_w = sb.pop_front();
        chk($sformatf("v%0d sb_word", i), data_out, exp_w);
      end
    end
    if (v.e_ar) sb.push_back(WA);
    if (v.e_br) sb.push_back(WB);
    @(posedge clk); #1;
    chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, v.e_ov});
    chk($sformatf("v%0d data_out", i), data_out, v.e_dout);
    chk($sformatf("v%0d last_grant", i), {31'd0, last_grant}, {31'd0, v.e_lg});
    exp_ov_pre = v.e_ov;
  endtask

  task automatic cyc(input logic av, input logic bv, input logic ordy);
    a_valid = av; b_valid = bv; out_ready = ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    //          av bv or  ar br sel  ov dout lg
    vt[0]  = '{1, 0, 1,  1, 0, 0,   1, WA, 0};  // A only
    vt[1]  = '{1, 1, 1,  0, 1, 1,   1, WB, 1};  // contention -> B
    vt[2]  = '{1, 1, 1,  1, 0, 0,   1, WA, 0};
    vt[3]  = '{1, 1, 1,  0, 1, 1,   1, WB, 1};
    vt[4]  = '{1, 1, 1,  1, 0, 0,   1, WA, 0};
    vt[5]  = '{1, 1, 0,  0, 0, 1,   1, WA, 0};  // backpressure
    vt[6]  = '{1, 1, 0,  0, 0, 1,   1, WA, 0};
    vt[7]  = '{1, 1, 0,  0, 0, 1,   1, WA, 0};
    vt[8]  = '{1, 1, 1,  0, 1, 1,   1, WB, 1};  // drain + accept together
    vt[9]  = '{0, 0, 1,  0, 0, 1,   0, WB, 1};  // idle drain
    vt[10] = '{0, 0, 1,  0, 0, 1,   0, WB, 1};
    vt[11] = '{0, 1, 0,  0, 1, 1,   1, WB, 1};  // empty stage accepts without out_ready
    vt[12] = '{1, 0, 0,  0, 0, 0,   1, WB, 1};  // A waits behind full stage
    vt[13] = '{1, 0, 1,  1, 0, 0,   1, WA, 0};
    vt[14] = '{0, 0, 1,  0, 0, 0,   0, WA, 0};

    exp_ov_pre = 1'b0;
    #12;
    // Reset state, with rst_n still asserted
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst last_grant", {31'd0, last_grant}, 32'd1);
    chk("rst a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst b_ready", {31'd0, b_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) step_chk(i);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end

    // Async reset while the output stage holds a word
    word_a = WA; word_b = WB;
    cyc(1, 0, 0);
    chk("pre_rst out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst data_out", data_out, 32'd0);
    chk("async_rst last_grant", {31'd0, last_grant}, 32'd1);
    a_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("post_rst a_ready", {31'd0, a_ready}, 32'd1);
    chk("post_rst b_ready", {31'd0, b_ready}, 32'd0);
    chk("post_rst sel", {31'd0, sel}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst data_out", data_out, WA);
    chk("post_rst last_grant", {31'd0, last_grant}, 32'd0);
    cyc(0, 0, 1);

`ifdef MUX_ARB_GRANT_CNT_EN
    cnt_clr = 1'b1;
    cyc(0, 0, 1);
    cnt_clr = 1'b0;
    chk("cnt_a cleared", {16'd0, cnt_a}, 32'd0);
    chk("cnt_b cleared", {16'd0, cnt_b}, 32'd0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1);
    cyc(0, 0, 1);
    chk("cnt_a five", {16'd0, cnt_a}, 32'd5);
    chk("cnt_b three", {16'd0, cnt_b}, 32'd3);
    cnt_clr = 1'b1;
    cyc(1, 0, 1);
    cnt_clr = 1'b0;
    chk("cnt_a clr_prio", {16'd0, cnt_a}, 32'd0);
    chk("cnt_b clr_prio", {16'd0, cnt_b}, 32'd0);
    cyc(0, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
